// File: rtl/sram_array_ctrl.sv
// Sequencer for a small SRAM row array: precharge the bitlines, raise one wordline,
// then either drive the bitlines (write) or fire the sense amps (read) before a one-cycle recover.
module sram_array_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int PRE_CYCLES = 2,
  parameter int WL_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 precharge,
  output logic [2**ADDR_W-1:0] wl,
  output logic                 bl_drive_en,
  output logic [DATA_W-1:0]    bl_wdata,
  output logic                 sense_en,
  input  logic [DATA_W-1:0]    bl_rdata
);

  localparam int NWL   = 2**ADDR_W;
  localparam int MAXC  = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);
  localparam logic [NWL-1:0]   WL_ONE   = NWL'(1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRECHARGE = 2'd1;
  localparam logic [1:0] ACCESS    = 2'd2;
  localparam logic [1:0] RECOVER   = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // State sequencing; the counter holds the remaining cycles after the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= CNT_ZERO;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= PRE_LOAD;
            state   <= PRECHARGE;
          end else begin
            cnt     <= CNT_ZERO;
          end
        end
        PRECHARGE: begin
          if (cnt == CNT_ZERO) begin
            cnt   <= WL_LOAD;
            state <= ACCESS;
          end else begin
            cnt   <= cnt - CNT_ONE;
          end
        end
        ACCESS: begin
          if (cnt == CNT_ZERO) begin
            if (!we_q) begin
              rdata_q <= bl_rdata;
            end else begin
              rdata_q <= rdata_q;
            end
            cnt   <= CNT_ZERO;
            state <= RECOVER;
          end else begin
            cnt   <= cnt - CNT_ONE;
          end
        end
        RECOVER: begin
          cnt   <= CNT_ZERO;
          state <= IDLE;
        end
        default: begin
          cnt   <= CNT_ZERO;
          state <= IDLE;
        end
      endcase
    end
  end

  // Array-side outputs decoded purely from registered state.
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    precharge   = 1'b0;
    wl          = {NWL{1'b0}};
    bl_drive_en = 1'b0;
    bl_wdata    = {DATA_W{1'b0}};
    sense_en    = 1'b0;
    case (state)
      IDLE:      req_ready = 1'b1;
      PRECHARGE: precharge = 1'b1;
      ACCESS: begin
        wl = WL_ONE << addr_q;
        if (we_q) begin
          bl_drive_en = 1'b1;
          bl_wdata    = wdata_q;
        end else begin
          sense_en    = (cnt == CNT_ZERO);
        end
      end
      RECOVER:   rsp_valid = 1'b1;
      default:   req_ready = 1'b0;
    endcase
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: doc/sram_array_ctrl.md
SRAM_ARRAY_CTRL -- requirements
Module: sram_array_ctrl

Parameters
REQ-001 SHALL have these parameters (name, default, meaning), one per line:
- ADDR_W, 3, row address width; array has 2**ADDR_W wordlines.
- DATA_W, 8, column count and data width.
- PRE_CYCLES, 2, bitline precharge duration in clocks; values below 1 are illegal.
- WL_CYCLES, 2, wordline-active duration in clocks; values below 1 are illegal.

Interface (name, direction, width, meaning)
REQ-002 SHALL have these ports, one per line:
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, controller can accept a request.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, row select.
- req_wdata, in, DATA_W, write data.
- rsp_valid, out, 1, one-cycle completion pulse, reads and writes.
- rsp_rdata, out, DATA_W, read data, held until the next read completes.
- precharge, out, 1, bitline precharge enable.
- wl, out, 2**ADDR_W, one-hot wordline drive.
- bl_drive_en, out, 1, write drivers force bitlines.
- bl_wdata, out, DATA_W, true-bitline write value; complement is derived in the array.
- sense_en, out, 1, sense-amp enable.
- bl_rdata, in, DATA_W, sensed true-bitline value.

Function
REQ-003 SHALL implement FSM states IDLE, PRECHARGE, ACCESS and RECOVER.
REQ-004 SHALL assert req_ready only in IDLE; a handshake is req_valid && req_ready at a rising edge.
REQ-005 SHALL, on handshake, latch req_we, req_addr and req_wdata, then enter PRECHARGE; later changes on the req_* inputs SHALL have no effect on the operation.
REQ-006 SHALL remain in PRECHARGE for exactly PRE_CYCLES clocks with precharge=1, then enter ACCESS.
REQ-007 SHALL remain in ACCESS for exactly WL_CYCLES clocks, driving wl[latched addr]=1 and all other wl bits 0.
REQ-008 SHALL, for a write, hold bl_drive_en=1 and bl_wdata=latched data for every ACCESS cycle.
REQ-009 SHALL, for a read, hold bl_drive_en=0, and assert sense_en in the final ACCESS cycle only.
REQ-010 SHALL, for a read, capture bl_rdata into rsp_rdata at the edge that ends the final ACCESS cycle.
REQ-011 SHALL leave rsp_rdata unchanged on writes.
REQ-012 SHALL spend exactly one clock in RECOVER with rsp_valid=1, then return to IDLE.
REQ-013 SHALL give total occupancy of PRE_CYCLES+WL_CYCLES+2 clocks from the handshake edge to the next possible handshake edge; there is no back-to-back pipelining.
REQ-014 SHALL never assert precharge together with any wl bit, nor bl_drive_en together with sense_en.
REQ-015 SHALL drive wl all-zero, bl_drive_en=0 and sense_en=0 in IDLE, PRECHARGE and RECOVER.
REQ-016 SHALL use saturating-free down-counters sized for max(PRE_CYCLES, WL_CYCLES) and reload them on every state entry.
REQ-017 SHALL drive bl_wdata to 0 whenever bl_drive_en=0.
REQ-018 SHALL decode all outputs from registered state only; there are no combinational input-to-output paths except none.

Reset
REQ-019 SHALL, while rst=1 and without waiting for a clock edge, force state IDLE and drive req_ready=1, rsp_valid=0, rsp_rdata=0, precharge=0, wl=0, bl_drive_en=0 and sense_en=0.
REQ-020 SHALL abort an in-flight operation when reset is asserted mid-operation: no rsp_valid and no rsp_rdata update afterwards.
REQ-021 SHALL allow the first handshake at the first rising edge after rst deasserts.

Verification (defaults; handshake at edge E0; "cycle n" is the cycle after edge En-1)
REQ-022 Read addr=5 with bl_rdata=0xA5 -> precharge=1 in cycles 1-2; wl=0x20 in cycles 3-4; sense_en in cycle 4 only; rsp_valid with rsp_rdata=0xA5 in cycle 5; req_ready=1 in cycle 6.
REQ-023 Write addr=2, data=0x3C -> wl=0x04, bl_drive_en=1 and bl_wdata=0x3C in cycles 3-4; sense_en stays 0; rsp_valid in cycle 5; rsp_rdata unchanged.
REQ-024 Hold req_valid=1 continuously with changing addr -> handshakes exactly 6 cycles apart, each using the addr present at its own handshake edge.
REQ-025 Assert rst in cycle 3 of a read -> wl=0 immediately; no rsp_valid; rsp_rdata=0; req_ready=1.
REQ-026 Every cycle of random traffic -> precharge&&|wl, bl_drive_en&&sense_en and $countones(wl)>1 are never true.
REQ-027 Parameters PRE_CYCLES=1, WL_CYCLES=1 -> read completes with rsp_valid in cycle 3 and the next handshake at edge E4.
